// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register offsets, TCON bit positions and defaults for timer_irq
package timer_pkg;

    // Word offsets decoded from Addr[3:2]
    typedef enum logic [1:0] {
        TH_OFS      = 2'd0,
        TL_OFS      = 2'd1,
        TCON_OFS    = 2'd2,
        SYSTICK_OFS = 2'd3
    } reg_ofs_e;

    // TCON bit positions
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // Peripheral window base; the block claims BASE .. BASE+0xF
    localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

    // Divider is 16 bits wide, so PRESCALE must lie in 1..PRESCALE_MAX
    localparam int unsigned PRESCALE_MAX = 65536;

    // Packs the control/status bits into the 32-bit TCON read view
    function automatic logic [31:0] tcon_word(input logic en, input logic ie, input logic st);
        return {29'd0, st, ie, en};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - 16-bit clock divider producing a one-cycle count-enable tick
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // Last divider value before the tick; PRESCALE=65536 maps to 16'hFFFF
    localparam logic [15:0] TERMINAL = 16'(PRESCALE - 1);

    logic [15:0] div_q;
    logic [15:0] div_d;

    // Count 0..PRESCALE-1 while enabled; hold at 0 when disabled so a fresh
    // enable always waits a full PRESCALE period before the first tick
    always_comb begin
        tick  = en && (div_q == TERMINAL);
        div_d = div_q;
        if (!en || tick) begin
            div_d = 16'd0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= 16'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped reload timer with level IRQ and free-running SysTick
module timer_irq
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter logic [31:0] BASE     = DEFAULT_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWr,
    input  logic        MemRd,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        IRQ,
    output logic [31:0] SysTick
);

    // Register state
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;
    logic [31:0] systick_q, systick_d;

    // Bus decode
    logic     sel_hit;
    reg_ofs_e ofs;
    logic     wr_hit;
    logic     wr_th;
    logic     wr_tl;
    logic     wr_tcon;

    // Counting control
    logic     en_eff;
    logic     tick;
    logic     overflow;

    // Byte lane bits are not part of the register decode
    logic     addr_lane_unused;
    assign addr_lane_unused = ^Addr[1:0];

    // Window hit, word offset and per-register write strobes
    always_comb begin
        sel_hit = (Addr[31:4] == BASE[31:4]);
        ofs     = reg_ofs_e'(Addr[3:2]);
        wr_hit  = MemWr && sel_hit;
        wr_th   = wr_hit && (ofs == TH_OFS);
        wr_tl   = wr_hit && (ofs == TL_OFS);
        wr_tcon = wr_hit && (ofs == TCON_OFS);
    end

    // A store that clears EN stops counting on its own edge; a store that
    // sets EN only starts counting from the following edge
    always_comb begin
        en_eff = en_q && !(wr_tcon && !WriteData[TCON_EN]);
    end

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_eff),
        .tick  (tick)
    );

    // Next-state for TH/TL/TCON/SYSTICK with CPU-store and overflow priorities
    always_comb begin
        overflow  = tick && (tl_q == 32'hFFFF_FFFF);

        th_d      = th_q;
        tl_d      = tl_q;
        en_d      = en_q;
        ie_d      = ie_q;
        st_d      = st_q;
        systick_d = systick_q + 32'd1;

        if (wr_th) begin
            th_d = WriteData;
        end

        // CPU store to TL wins; a reload always uses the TH value held before this edge
        if (wr_tl) begin
            tl_d = WriteData;
        end else if (tick) begin
            tl_d = overflow ? th_q : (tl_q + 32'd1);
        end

        if (wr_tcon) begin
            en_d = WriteData[TCON_EN];
            ie_d = WriteData[TCON_IE];
            st_d = WriteData[TCON_ST];
        end

        // A fresh overflow must never be lost to a concurrent clearing store
        if (overflow && ie_q) begin
            st_d = 1'b1;
        end
    end

    // Register file state
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            st_q      <= 1'b0;
            systick_q <= 32'd0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            st_q      <= st_d;
            systick_q <= systick_d;
        end
    end

    // Zero-latency read mux, driven to 0 whenever the block is not addressed for a load
    always_comb begin
        ReadData = 32'd0;
        if (sel_hit && MemRd) begin
            unique case (ofs)
                TH_OFS:      ReadData = th_q;
                TL_OFS:      ReadData = tl_q;
                TCON_OFS:    ReadData = tcon_word(en_q, ie_q, st_q);
                SYSTICK_OFS: ReadData = systick_q;
                default:     ReadData = 32'd0;
            endcase
        end
    end

    // Outputs straight from the decode and registers
    always_comb begin
        Sel     = sel_hit;
        IRQ     = ie_q && st_q;
        SysTick = systick_q;
    end

endmodule
